// File: rtl/channel_accumulator.sv
// Accumulates NUM_CHANNELS signed window sums plus a bias into one pixel, then shifts,
// optionally applies ReLU (define CHANNEL_ACC_RELU_EN) and saturates to OUT_WIDTH bits.
module channel_accumulator #(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned ACC_WIDTH    = 40,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned SHIFT        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [31:0]          in_data,
  input  logic [31:0]          bias,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 sat_flag,
  output logic                 busy
);

  localparam int unsigned CntW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_CHANNELS - 1);
  localparam logic signed [ACC_WIDTH-1:0] OutMax =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OutMin =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic [CntW-1:0]             cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                        fire_q, fire_d;
  logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
  logic                        out_valid_q;
  logic                        sat_q, sat_d;

  logic signed [ACC_WIDTH-1:0] data_ext, bias_ext, acc_base, shifted, act;

  // Stage 1: channel counting and group summation.
  always_comb begin
    data_ext = {{(ACC_WIDTH - 32){in_data[31]}}, in_data};
    bias_ext = {{(ACC_WIDTH - 32){bias[31]}}, bias};
    // Channel 0 starts from zero so a new group never inherits the old sum.
    acc_base = (cnt_q == '0) ? '0 : acc_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    fire_d   = 1'b0;
    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (in_valid) begin
      if (cnt_q == LastCnt) begin
        sum_d  = acc_base + data_ext + bias_ext;
        fire_d = 1'b1;
        cnt_d  = '0;
        acc_d  = '0;
      end else begin
        acc_d = acc_base + data_ext;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Stage 2: shift, activation and saturation.
  always_comb begin
    shifted = sum_q >>> SHIFT;
    act     = shifted;
`ifdef CHANNEL_ACC_RELU_EN
    if (shifted[ACC_WIDTH-1]) begin
      act = '0;
    end
`endif
    out_data_d = out_data_q;
    sat_d      = 1'b0;
    if (fire_q) begin
      if (act > OutMax) begin
        out_data_d = OutMax[OUT_WIDTH-1:0];
        sat_d      = 1'b1;
      end else if (act < OutMin) begin
        out_data_d = OutMin[OUT_WIDTH-1:0];
        sat_d      = 1'b1;
      end else begin
        out_data_d = act[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      fire_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      fire_q      <= fire_d;
      out_data_q  <= out_data_d;
      out_valid_q <= fire_q;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_channel_accumulator.sv
// Bench for channel_accumulator: SHIFT=0 and SHIFT=8 instances driven in parallel and
// compared against a group-level arithmetic model.
module tb_channel_accumulator;

  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] bias = '0;

  logic        ov0, ov8, sf0, sf8, busy0, busy8;
  logic [15:0] od0, od8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  channel_accumulator #(
    .NUM_CHANNELS(NCH), .ACC_WIDTH(40), .OUT_WIDTH(16), .SHIFT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .bias(bias), .out_valid(ov0), .out_data(od0), .sat_flag(sf0), .busy(busy0)
  );

  channel_accumulator #(
    .NUM_CHANNELS(NCH), .ACC_WIDTH(40), .OUT_WIDTH(16), .SHIFT(8)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .bias(bias), .out_valid(ov8), .out_data(od8), .sat_flag(sf8), .busy(busy8)
  );

  // Reference model state
  longint      grp[$];
  logic        pv = 1'b0;
  logic [15:0] pd0 = '0, pd8 = '0;
  logic        ps0 = 1'b0, ps8 = 1'b0;
  logic [15:0] ld0 = '0, ld8 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pixel(input longint s, input int sh, output logic [15:0] d, output logic sat);
    longint v;
    v   = (s <<< 24) >>> 24;  // wrap to 40-bit two's complement
    v   = v >>> sh;
`ifdef CHANNEL_ACC_RELU_EN
    if (v < 0) v = 0;
`endif
    sat = 1'b0;
    if (v > 32767) begin
      v = 32767; sat = 1'b1;
    end else if (v < -32768) begin
      v = -32768; sat = 1'b1;
    end
    d = v[15:0];
  endtask

  task automatic model_reset();
    grp.delete();
    pv = 1'b0; ps0 = 1'b0; ps8 = 1'b0;
    ld0 = '0; ld8 = '0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [31:0] b,
                      input logic c);
    logic        ev, es0, es8;
    logic [15:0] e0, e8;
    longint      s;
    in_valid = v; in_data = d; bias = b; clear = c;
    @(posedge clk);
    ev = pv; e0 = pd0; e8 = pd8; es0 = ps0; es8 = ps8;
    pv = 1'b0;
    if (c) begin
      grp.delete();
    end else if (v) begin
      grp.push_back(longint'($signed(d)));
      if (grp.size() == NCH) begin
        s = longint'($signed(b));
        foreach (grp[i]) s += grp[i];
        pixel(s, 0, pd0, ps0);
        pixel(s, 8, pd8, ps8);
        pv = 1'b1;
        grp.delete();
      end
    end
    #1;
    if (ev) begin
      ld0 = e0; ld8 = e8;
    end
    chk("valid0", 32'(ov0), 32'(ev));
    chk("valid8", 32'(ov8), 32'(ev));
    chk("data0", 32'(od0), 32'(ld0));
    chk("data8", 32'(od8), 32'(ld8));
    chk("sat0", 32'(sf0), 32'(ev & es0));
    chk("sat8", 32'(sf8), 32'(ev & es8));
    chk("busy0", 32'(busy0), 32'(grp.size() != 0));
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(ov0), 32'd0);
    chk("rst_data", 32'(od0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    idle(1);

    // 5,7,9 + bias 10 -> 31, two cycles after the last sample is driven
    step(1'b1, 32'd5, 32'd10, 1'b0);
    step(1'b1, 32'd7, 32'd10, 1'b0);
    step(1'b1, 32'd9, 32'd10, 1'b0);
    chk("lat_early", 32'(ov0), 32'd0);
    step(1'b0, '0, '0, 1'b0);
    chk("req034_data", 32'(od0), 32'd31);
    chk("req034_valid", 32'(ov0), 32'd1);
    step(1'b0, '0, '0, 1'b0);
    chk("pulse_single", 32'(ov0), 32'd0);
    chk("hold_data", 32'(od0), 32'd31);

    // back-to-back groups
    for (int i = 0; i < 3; i++) step(1'b1, 32'd1, 32'd0, 1'b0);
    step(1'b1, 32'd2, 32'd0, 1'b0);
    chk("b2b_first", 32'(od0), 32'd3);
    step(1'b1, 32'd2, 32'd0, 1'b0);
    step(1'b1, 32'd2, 32'd0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    chk("b2b_second", 32'(od0), 32'd6);
    chk("b2b_valid", 32'(ov0), 32'd1);

    // positive saturation and shift
    step(1'b1, 32'd40000, 32'd0, 1'b0);
    step(1'b1, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'd0, 32'd0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    chk("pos_sat_data", 32'(od0), 32'h7fff);
    chk("pos_sat_flag", 32'(sf0), 32'd1);
    chk("shift8_data", 32'(od8), 32'd156);
    chk("shift8_flag", 32'(sf8), 32'd0);

    // negative values
    step(1'b1, -32'sd100, 32'd0, 1'b0);
    step(1'b1, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'd0, 32'd0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
`ifdef CHANNEL_ACC_RELU_EN
    chk("neg100", 32'(od0), 32'd0);
`else
    chk("neg100", 32'(od0), 32'hff9c);
`endif
    step(1'b1, -32'sd40000, 32'd0, 1'b0);
    step(1'b1, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'd0, 32'd0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
`ifdef CHANNEL_ACC_RELU_EN
    chk("neg_sat_data", 32'(od0), 32'd0);
    chk("neg_sat_flag", 32'(sf0), 32'd0);
`else
    chk("neg_sat_data", 32'(od0), 32'h8000);
    chk("neg_sat_flag", 32'(sf0), 32'd1);
`endif

    // clear mid-group, clear overriding a sample, then a fresh group
    step(1'b1, 32'd9, 32'd0, 1'b0);
    step(1'b1, 32'd9, 32'd0, 1'b0);
    step(1'b1, 32'd9, 32'd0, 1'b1);
    chk("clear_busy", 32'(busy0), 32'd0);
    step(1'b1, 32'd4, 32'd0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, 32'd4, 32'd0, 1'b0);
    step(1'b1, 32'd4, 32'd0, 1'b0);
    // clear on the cycle after capture must not cancel the pixel
    step(1'b0, '0, '0, 1'b1);
    chk("clear_keeps", 32'(od0), 32'd12);

    // reset pulsed mid-group
    step(1'b1, 32'd50, 32'd0, 1'b0);
    step(1'b1, 32'd50, 32'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_data", 32'(od0), 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 32'd50, 32'd0, 1'b0);
    idle(3);
    chk("postrst_busy", 32'(busy0), 32'd1);
    step(1'b1, 32'd1, 32'd2, 1'b0);
    step(1'b1, 32'd1, 32'd2, 1'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d, b;
      d = $urandom;
      if ($urandom_range(0, 2) != 0) d = 32'($signed($urandom_range(0, 200000)) - 100000);
      b = 32'($signed($urandom_range(0, 2000)) - 1000);
      step(($urandom_range(0, 9) < 7), d, b, ($urandom_range(0, 19) == 0));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
